// File: rtl/instr_fetch_if.sv
// Fetch/response and program-load signal bundle between the PC side (master)
// and the instruction-memory responder (slave).
interface instr_fetch_if #(
    parameter int DEPTH_WORDS = 1024
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic          instr_read;
    logic [31:0]   instr_addr;
    logic          req_ready;
    logic [31:0]   instr_out;
    logic          instr_valid;
    logic          instr_err;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          busy;

    modport master (
        output instr_read, instr_addr, load_en, load_addr, load_data,
        input  req_ready, instr_out, instr_valid, instr_err, busy
    );

    modport slave (
        input  instr_read, instr_addr, load_en, load_addr, load_data,
        output req_ready, instr_out, instr_valid, instr_err, busy
    );
endinterface

// File: rtl/instr_fetch_responder.sv
// Instruction-memory responder: accepts one fetch at a time (or back-to-back),
// answers after LATENCY cycles with a one-cycle valid strobe, flags misaligned
// and out-of-range fetches, and exposes a program-load write port.
module instr_fetch_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic         clk,
    input  logic         rst,
    instr_fetch_if.slave bus
);

    localparam int          AW  = $clog2(DEPTH_WORDS);
    localparam logic [31:0] NOP = 32'h0000_0013;   // addi x0, x0, 0

    if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
        $error("instr_fetch_responder: LATENCY must be in 1..7 (3-bit countdown)");
    end
    if (DEPTH_WORDS < 16 || DEPTH_WORDS > 4096 ||
        (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("instr_fetch_responder: DEPTH_WORDS must be a power of two in 16..4096");
    end

    typedef enum logic [1:0] { S_IDLE, S_WAIT, S_RESP } state_t;

    state_t      state, state_next;
    logic [2:0]  cnt, cnt_next;
    logic [31:0] addr_q;
    logic        accept;
    logic [31:0] resp_addr;
    logic [29:0] resp_word;
    logic        resp_err;
    logic [31:0] resp_data;
    logic        valid_q;
    logic        err_q;
    logic [31:0] out_q;
    logic [31:0] mem [DEPTH_WORDS];

    // A load in progress blocks new fetches; reset holds the port closed.
    assign bus.req_ready   = (state == S_IDLE || state == S_RESP) && !bus.load_en && !rst;
    assign accept          = bus.instr_read && bus.req_ready;
    assign bus.busy        = (state == S_WAIT) || (state == S_RESP);
    assign bus.instr_valid = valid_q;
    assign bus.instr_err   = err_q;
    assign bus.instr_out   = out_q;

    // Next state and latency countdown
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_next = S_IDLE;
        cnt_next   = cnt;
        case (state)
            S_WAIT: begin
                cnt_next = cnt - 3'd1;
                if (cnt == 3'd1) state_next = S_RESP;
                else             state_next = S_WAIT;
            end
            default: begin
                // IDLE and RESP both accept; RESP always lasts one cycle.
                if (accept) begin
                    cnt_next = 3'(LATENCY - 1);
                    if (LATENCY > 1) state_next = S_WAIT;
                    else             state_next = S_RESP;
                end
            end
        endcase
    end

    // Response word for the edge that enters RESP (write-first on a same-word load)
    always_comb begin
        // With LATENCY=1 the response is built straight from the accepting cycle's address.
        resp_addr = (state == S_WAIT) ? addr_q : bus.instr_addr;
        resp_word = resp_addr[31:2];
        // Full-width compare: high address bits never alias back into range.
        resp_err  = (resp_addr[1:0] != 2'b00) || (resp_word >= 30'(DEPTH_WORDS));
        if (resp_err)
            resp_data = NOP;
        else if (bus.load_en && bus.load_addr == resp_word[AW-1:0])
            resp_data = bus.load_data;
        else
            resp_data = mem[resp_word[AW-1:0]];
    end

    // State, captured address and registered response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            state   <= state_next;
            cnt     <= cnt_next;
            if (accept) addr_q <= bus.instr_addr;
            valid_q <= (state_next == S_RESP);
            err_q   <= (state_next == S_RESP) && resp_err;
            if (state_next == S_RESP) out_q <= resp_data;
        end
    end

    // Instruction store write port
    always_ff @(posedge clk) begin
        // NOTE: the array is intentionally not reset; loaded programs survive
        // a reset, and a reset port would prevent RAM inference.
        if (bus.load_en) mem[bus.load_addr] <= bus.load_data;
    end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Bench for instr_fetch_responder: three instances (LATENCY 2, 1, 4) share one
// stimulus stream; a cycle-indexed behavioural model predicts every output.
module tb_instr_fetch_responder;

    localparam int DEPTH = 1024;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        instr_read = 1'b0;
    logic [31:0] instr_addr = '0;
    logic        load_en    = 1'b0;
    logic [9:0]  load_addr  = '0;
    logic [31:0] load_data  = '0;

    int n_tests = 0;
    int n_fail  = 0;

    int lat [3] = '{2, 1, 4};

    logic        d_ready [3];
    logic        d_valid [3];
    logic        d_err   [3];
    logic        d_busy  [3];
    logic [31:0] d_out   [3];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        instr_fetch_if #(.DEPTH_WORDS(DEPTH)) bus ();
        assign bus.instr_read = instr_read;
        assign bus.instr_addr = instr_addr;
        assign bus.load_en    = load_en;
        assign bus.load_addr  = load_addr;
        assign bus.load_data  = load_data;
        assign d_ready[k]     = bus.req_ready;
        assign d_valid[k]     = bus.instr_valid;
        assign d_err[k]       = bus.instr_err;
        assign d_busy[k]      = bus.busy;
        assign d_out[k]       = bus.instr_out;

        instr_fetch_responder #(
            .DEPTH_WORDS(DEPTH),
            .LATENCY((k == 0) ? 2 : (k == 1) ? 1 : 4)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Cycle n is the period after the n-th rising edge. A fetch accepted at the
    // end of cycle c is answered during cycle c+L and is in flight c+1..c+L.
    longint      m_cyc = 0;
    logic        m_inflight [3];
    longint      m_due      [3];
    logic [31:0] m_addr     [3];
    logic        m_valid    [3];
    logic        m_err      [3];
    logic [31:0] m_out      [3];
    logic [31:0] m_mem      [DEPTH];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_inflight[k] = 1'b0;
                m_due[k]      = 0;
                m_addr[k]     = '0;
                m_valid[k]    = 1'b0;
                m_err[k]      = 1'b0;
                m_out[k]      = '0;
            end
        end else begin
            // Loads land before the response is read: same-word writes are seen.
            if (load_en) m_mem[load_addr] = load_data;
            for (int k = 0; k < 3; k++) begin
                logic rdy;
                longint word;
                logic bad;
                rdy = !load_en && !(m_inflight[k] && m_due[k] > m_cyc);
                if (instr_read && rdy) begin
                    m_inflight[k] = 1'b1;
                    m_due[k]      = m_cyc + lat[k];
                    m_addr[k]     = instr_addr;
                end
                m_valid[k] = m_inflight[k] && (m_due[k] == m_cyc + 1);
                m_err[k]   = 1'b0;
                if (m_valid[k]) begin
                    word = longint'(m_addr[k]) / 4;
                    bad  = (m_addr[k] % 4 != 0) || (word >= DEPTH);
                    m_err[k] = bad;
                    m_out[k] = bad ? 32'h0000_0013 : m_mem[int'(word)];
                end
            end
            m_cyc = m_cyc + 1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        #2;
        for (int k = 0; k < 3; k++) begin
            logic exp_rdy;
            logic exp_busy;
            exp_rdy  = !rst && !load_en && !(m_inflight[k] && m_due[k] > m_cyc);
            exp_busy = m_inflight[k] && (m_cyc <= m_due[k]);
            check($sformatf("L%0d_req_ready", lat[k]), d_ready[k], exp_rdy);
            check($sformatf("L%0d_busy", lat[k]),      d_busy[k],  exp_busy);
            check($sformatf("L%0d_valid", lat[k]),     d_valid[k], m_valid[k]);
            check($sformatf("L%0d_err", lat[k]),       d_err[k],   m_err[k]);
            check($sformatf("L%0d_out", lat[k]),       d_out[k],   m_out[k]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            instr_read = 1'b0;
            load_en    = 1'b0;
        end
    endtask

    task automatic wait_valid(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            #3;
            if (d_valid[k]) ok = 1'b1;
        end
        check($sformatf("L%0d_wait_valid", lat[k]), {31'b0, ok}, 32'd1);
    endtask

    // One fetch into an idle instance k (LATENCY >= 2), checked against literals.
    task automatic fetch_check(input int k, input logic [31:0] a,
                               input logic [31:0] exp_o, input logic exp_e, input string nm);
        bit ok;
        @(negedge clk);
        instr_read = 1'b1;
        instr_addr = a;
        @(negedge clk);
        instr_read = 1'b0;
        wait_valid(k, ok);
        check({nm, "_out"},       d_out[k], exp_o);
        check({nm, "_err"},       d_err[k], exp_e);
        check({nm, "_model_out"}, m_out[k], exp_o);
        idle(6);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] w;
        w = 32'($urandom_range(0, 63));
        case ($urandom_range(0, 9))
            0:       return (w << 2) | 32'($urandom_range(1, 3));
            1:       return 32'($urandom_range(1024, 4095)) << 2;
            2:       return $urandom() | 32'h0000_1000;
            3:       return 32'h0000_0FFC;
            default: return w << 2;
        endcase
    endfunction

    logic [31:0] prog [4] = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0000_006F};

    // ---------------- stimulus ----------------
    initial begin
        #1 rst = 1'b1;
        idle(3);
        #3;
        check("rst_req_ready", d_ready[0], 32'd0);
        check("rst_valid",     d_valid[0], 32'd0);
        check("rst_out",       d_out[0],   32'd0);
        check("rst_busy",      d_busy[0],  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Program load: four known words, random filler, pinned last word.
        for (int w = 0; w < 64; w++) begin
            @(negedge clk);
            load_en   = 1'b1;
            load_addr = 10'(w);
            load_data = (w < 4) ? prog[w] : $urandom();
        end
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = 10'd1023;
        load_data = 32'hCAFE_F00D;
        idle(4);

        // Single fetch of 0x4, LATENCY=2.
        @(negedge clk);
        instr_read = 1'b1;
        instr_addr = 32'h4;
        @(negedge clk);
        instr_read = 1'b0;
        #3;
        check("t1_busy_t+1",  d_busy[0],  32'd1);
        check("t1_valid_t+1", d_valid[0], 32'd0);
        @(negedge clk);
        #3;
        check("t1_valid_t+2",     d_valid[0], 32'd1);
        check("t1_out",           d_out[0],   32'h00A0_0113);
        check("t1_err",           d_err[0],   32'd0);
        check("t1_model_out",     m_out[0],   32'h00A0_0113);
        @(negedge clk);
        #3;
        check("t1_valid_t+3", d_valid[0], 32'd0);
        check("t1_out_held",  d_out[0],   32'h00A0_0113);
        idle(8);

        // Back-to-back fetches, LATENCY=1 instance.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            instr_read = 1'b1;
            instr_addr = 32'(i * 4);
            #3;
            check($sformatf("b2b_ready_%0d", i), d_ready[1], 32'd1);
            if (i > 0) begin
                check($sformatf("b2b_valid_%0d", i - 1), d_valid[1], 32'd1);
                check($sformatf("b2b_out_%0d", i - 1),   d_out[1],   prog[i - 1]);
            end
        end
        @(negedge clk);
        instr_read = 1'b0;
        #3;
        check("b2b_valid_3", d_valid[1], 32'd1);
        check("b2b_out_3",   d_out[1],   prog[3]);
        @(negedge clk);
        #3;
        check("b2b_valid_end", d_valid[1], 32'd0);
        idle(8);

        // Misaligned, out-of-range, boundary and high-bit addresses.
        fetch_check(0, 32'h0000_0006, 32'h0000_0013, 1'b1, "misaligned");
        fetch_check(0, 32'h0000_1000, 32'h0000_0013, 1'b1, "out_of_range");
        fetch_check(0, 32'h0000_0008, 32'h0020_81B3, 1'b0, "after_err");
        fetch_check(0, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, "last_word");
        fetch_check(0, 32'hFFFF_FFFC, 32'h0000_0013, 1'b1, "high_bits");
        idle(4);

        // load_en held with instr_read: no accept.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            instr_read = 1'b1;
            instr_addr = 32'h10;
            load_en    = 1'b1;
            load_addr  = 10'd5;
            load_data  = 32'h1234_5678;
            #3;
            for (int k = 0; k < 3; k++)
                check($sformatf("load_block_ready_L%0d", lat[k]), d_ready[k], 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            instr_read = 1'b0;
            load_en    = 1'b0;
            #3;
            check("load_block_no_valid", d_valid[0], 32'd0);
        end

        // Write-first bypass on the RESP-entry edge.
        @(negedge clk);
        instr_read = 1'b1;
        instr_addr = 32'h0;
        @(negedge clk);
        instr_read = 1'b0;
        load_en    = 1'b1;
        load_addr  = 10'd0;
        load_data  = 32'hDEAD_BEEF;
        #3;
        check("bypass_busy_wait", d_busy[0], 32'd1);
        @(negedge clk);
        load_en = 1'b0;
        #3;
        check("bypass_valid",     d_valid[0], 32'd1);
        check("bypass_out",       d_out[0],   32'hDEAD_BEEF);
        check("bypass_err",       d_err[0],   32'd0);
        check("bypass_model_out", m_out[0],   32'hDEAD_BEEF);
        idle(8);

        // Reset mid-WAIT on the LATENCY=4 instance.
        @(negedge clk);
        instr_read = 1'b1;
        instr_addr = 32'hC;
        @(negedge clk);
        instr_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #3;
        check("midrst_busy",  d_busy[2],  32'd0);
        check("midrst_out",   d_out[2],   32'd0);
        check("midrst_valid", d_valid[2], 32'd0);
        check("midrst_ready", d_ready[2], 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #3;
            check("midrst_no_resp",       d_valid[2], 32'd0);
            check("midrst_model_no_resp", m_valid[2], 32'd0);
        end
        fetch_check(2, 32'h0000_000C, 32'h0000_006F, 1'b0, "after_rst");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!rst && $urandom_range(0, 249) == 0) begin
                rst        = 1'b1;
                instr_read = 1'b0;
                load_en    = 1'b0;
            end else begin
                rst        = 1'b0;
                instr_read = 1'($urandom_range(0, 1));
                instr_addr = rand_addr();
                load_en    = ($urandom_range(0, 9) == 0);
                load_addr  = ($urandom_range(0, 15) == 0) ? 10'd1023 : 10'($urandom_range(0, 63));
                load_data  = $urandom();
            end
        end
        @(negedge clk);
        rst = 1'b0;
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
